// File: rtl/user_pkg.sv
// Shared user-domain types: register port bundles and
// conv1d accelerator register map / job descriptor.
package user_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    localparam logic [31:0] Conv1dSrcOff  = 32'h0;
    localparam logic [31:0] Conv1dDstOff  = 32'h4;
    localparam logic [31:0] Conv1dLenOff  = 32'h8;
    localparam logic [31:0] Conv1dCtrlOff = 32'hC;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
    } conv1d_desc_t;

endpackage

// File: rtl/desc_fifo.sv
// Synchronous FIFO with registered full/empty flags
// and an occupancy count; head is the oldest entry.
module desc_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 80
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [Width-1:0]       wdata,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count,
    output logic [Width-1:0]       head
);
    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0]     mem [Depth];
    logic [AddrW-1:0]     wptr;
    logic [AddrW-1:0]     rptr;
    logic [$clog2(Depth):0] cnt_n;
    logic                 push_en;
    logic                 pop_en;

    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem[rptr];

    // Next occupancy; simultaneous push and pop cancel out.
    always_comb begin
        cnt_n = count;
        if (push_en && !pop_en) begin
            cnt_n = count + 1'b1;
        end else if (pop_en && !push_en) begin
            cnt_n = count - 1'b1;
        end
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers, count and flags registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push_en) wptr <= wptr + 1'b1;
            if (pop_en)  rptr <= rptr + 1'b1;
            count <= cnt_n;
            full  <= (cnt_n == ($clog2(Depth)+1)'(Depth));
            empty <= (cnt_n == '0);
        end
    end

endmodule

// File: rtl/conv1d_job_sched.sv
// Job queue that replays descriptors into the conv1d
// accelerator and raises an interrupt per finished job.
module conv1d_job_sched
    import user_pkg::*;
#(
    parameter int unsigned QueueDepth = 4,
    parameter logic [31:0] AccBase    = 32'h0
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output reg_req_t acc_reg_req_o,
    input  reg_rsp_t acc_reg_rsp_i,
    input  logic     acc_done_i,
    output logic     irq_o
);
    localparam int unsigned CntW = $clog2(QueueDepth) + 1;

    typedef enum logic [2:0] {
        IDLE, WR_SRC, WR_DST, WR_LEN, WR_START, WAIT_DONE
    } state_e;

    state_e       state_q, state_d;
    logic [31:0]  src_q, dst_q;
    logic [15:0]  len_q, done_cnt_q;
    logic         enable_q, pending_q, acc_err_q;
    logic         done_prev_q;
    logic [4:0]   off;
    logic         sw_wr, push, pop, full, empty;
    logic         irq_clr, wr_state, busy;
    logic         hs, job_err, job_done;
    logic [CntW-1:0] count;
    logic [3:0]   cnt4;
    conv1d_desc_t head, new_desc;
    logic         unused_bits;

    assign off      = reg_req_i.addr[4:0];
    assign sw_wr    = reg_req_i.valid & reg_req_i.write;
    assign push     = sw_wr & (off == 5'h0C);
    assign irq_clr  = sw_wr & (off == 5'h18) & reg_req_i.wdata[1];
    assign new_desc = '{src: src_q, dst: dst_q, len: len_q};
    assign cnt4     = 4'(count);
    assign busy     = (state_q != IDLE);
    assign wr_state = state_q inside {WR_SRC, WR_DST, WR_LEN, WR_START};
    assign hs       = wr_state & acc_reg_rsp_i.ready;
    assign job_err  = hs & acc_reg_rsp_i.error;
    assign job_done = (state_q == WAIT_DONE) & acc_done_i & ~done_prev_q;
    assign pop      = job_err | job_done;
    assign irq_o    = pending_q & enable_q;
    assign unused_bits = ^{reg_req_i.addr[31:5], reg_req_i.wstrb,
                           acc_reg_rsp_i.rdata};

    desc_fifo #(
        .Depth (QueueDepth),
        .Width ($bits(conv1d_desc_t))
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .wdata (new_desc),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state: walk the four writes, then wait for done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!empty) state_d = WR_SRC;
            WR_SRC:    if (hs) state_d = WR_DST;
            WR_DST:    if (hs) state_d = WR_LEN;
            WR_LEN:    if (hs) state_d = WR_START;
            WR_START:  if (hs) state_d = WAIT_DONE;
            WAIT_DONE: if (job_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (job_err) state_d = IDLE;
    end

    // Accelerator write request for the head descriptor.
    always_comb begin
        acc_reg_req_o = '0;
        if (wr_state) begin
            acc_reg_req_o.valid = 1'b1;
            acc_reg_req_o.write = 1'b1;
            acc_reg_req_o.wstrb = 4'hF;
        end
        unique case (state_q)
            WR_SRC: begin
                acc_reg_req_o.addr  = AccBase + Conv1dSrcOff;
                acc_reg_req_o.wdata = head.src;
            end
            WR_DST: begin
                acc_reg_req_o.addr  = AccBase + Conv1dDstOff;
                acc_reg_req_o.wdata = head.dst;
            end
            WR_LEN: begin
                acc_reg_req_o.addr  = AccBase + Conv1dLenOff;
                acc_reg_req_o.wdata = {16'h0, head.len};
            end
            WR_START: begin
                acc_reg_req_o.addr  = AccBase + Conv1dCtrlOff;
                acc_reg_req_o.wdata = 32'h1;
            end
            default: ;
        endcase
    end

    // Software read mux and error decode, always ready.
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = 1'b1;
        if (reg_req_i.valid) begin
            case (off)
                5'h00: reg_rsp_o.rdata = src_q;
                5'h04: reg_rsp_o.rdata = dst_q;
                5'h08: reg_rsp_o.rdata = {16'h0, len_q};
                5'h0C: reg_rsp_o.error = reg_req_i.write & full;
                5'h10: reg_rsp_o.rdata = {24'h0, cnt4, acc_err_q,
                                          full, empty, busy};
                5'h14: reg_rsp_o.rdata = {16'h0, done_cnt_q};
                5'h18: reg_rsp_o.rdata = {30'h0, pending_q, enable_q};
                default: reg_rsp_o.error = 1'b1;
            endcase
        end
    end

    // Descriptor staging registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
        end else if (sw_wr) begin
            case (off)
                5'h00: src_q <= reg_req_i.wdata;
                5'h04: dst_q <= reg_req_i.wdata;
                5'h08: len_q <= reg_req_i.wdata[15:0];
                default: ;
            endcase
        end
    end

    // Completion counter, interrupt and sticky error state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_prev_q <= 1'b0;
            done_cnt_q  <= '0;
            enable_q    <= 1'b0;
            pending_q   <= 1'b0;
            acc_err_q   <= 1'b0;
        end else begin
            done_prev_q <= acc_done_i;
            if (sw_wr && off == 5'h14) done_cnt_q <= '0;
            else if (job_done)         done_cnt_q <= done_cnt_q + 1'b1;
            if (sw_wr && off == 5'h18) enable_q <= reg_req_i.wdata[0];
            if (job_done && enable_q)  pending_q <= 1'b1;
            else if (irq_clr)          pending_q <= 1'b0;
            if (job_err)               acc_err_q <= 1'b1;
            else if (irq_clr)          acc_err_q <= 1'b0;
        end
    end

endmodule
